// File: rtl/grn_pkg.sv
// Shared types and sizing constants for the GRN result write path.
package grn_pkg;

    localparam int GRN_LINE_WIDTH = 512;
    localparam int GRN_WQ_DEPTH   = 16;

    typedef logic [GRN_LINE_WIDTH-1:0] t_grn_line;
    typedef logic [31:0]               t_grn_line_idx;

    typedef enum logic {
        GRN_WQ_IDLE,
        GRN_WQ_ACK
    } t_grn_wq_state;

endpackage

// File: rtl/grn_wq_ram.sv
// DEPTH x WIDTH line storage: one synchronous write port, one asynchronous read port.
module grn_wq_ram #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read gives the first-word-fall-through head.
    assign rdata = mem[raddr];

endmodule

// File: rtl/grn_write_queue.sv
// Decoupling FIFO between the top_grn line producer and the CCI-P c1 write path;
// FWFT head with a running line index used as the write-address offset.
module grn_write_queue
    import grn_pkg::*;
#(
    parameter int LINE_WIDTH   = GRN_LINE_WIDTH,
    parameter int DEPTH        = GRN_WQ_DEPTH,
    parameter int AFULL_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     req_write,
    input  logic [LINE_WIDTH-1:0]    transient,
    output logic                     ack_write,
    output logic                     out_valid,
    output logic [LINE_WIDTH-1:0]    out_data,
    output t_grn_line_idx            out_line_idx,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output t_grn_line_idx            lines_in
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam t_grn_line_idx    IDX_ONE  = 32'd1;

    t_grn_wq_state    state_q;
    t_grn_wq_state    state_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             afull_q;
    t_grn_line_idx    line_idx_q;
    t_grn_line_idx    lines_in_q;
    logic             push;
    logic             pop;

    // Accept FSM: the ACK cycle is a dead cycle for req_write, so a producer that
    // drops its request on seeing ack_write can never be accepted twice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= GRN_WQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        ack_write = 1'b0;
        case (state_q)
            GRN_WQ_IDLE: begin
                if (!clear && req_write && (count_q < FULL_CNT)) begin
                    push    = 1'b1;
                    state_d = GRN_WQ_ACK;
                end
            end
            GRN_WQ_ACK: begin
                ack_write = !clear;
                state_d   = GRN_WQ_IDLE;
            end
            default: state_d = GRN_WQ_IDLE;
        endcase
    end

    assign pop = (count_q != '0) && out_ready && !clear;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointers, occupancy and line counters; almost_full tracks count_d so both
    // registers present the same occupancy in every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            afull_q    <= 1'b0;
            line_idx_q <= '0;
            lines_in_q <= '0;
        end else begin
            count_q <= count_d;
            afull_q <= (count_d >= AF_CNT);
            if (clear) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                line_idx_q <= '0;
                lines_in_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q   <= wr_ptr_q + PTR_ONE;
                    lines_in_q <= lines_in_q + IDX_ONE;
                end
                if (pop) begin
                    rd_ptr_q   <= rd_ptr_q + PTR_ONE;
                    line_idx_q <= line_idx_q + IDX_ONE;
                end
            end
        end
    end

    grn_wq_ram #(
        .WIDTH (LINE_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (transient),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );

    assign out_valid    = (count_q != '0);
    assign count        = count_q;
    assign almost_full  = afull_q;
    assign out_line_idx = line_idx_q;
    assign lines_in     = lines_in_q;

endmodule

// File: tb/tb_grn_write_queue.sv
// Bench for grn_write_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_grn_write_queue;
    import grn_pkg::*;

    localparam int W     = 512;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          clear     = 1'b0;
    logic          req_write = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  transient = '0;
    logic          ack_write;
    logic          out_valid;
    logic [W-1:0]  out_data;
    t_grn_line_idx out_line_idx;
    logic [4:0]    count;
    logic          almost_full;
    t_grn_line_idx lines_in;

    int n_cmp  = 0;
    int n_fail = 0;

    grn_write_queue #(
        .LINE_WIDTH   (W),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .req_write    (req_write),
        .transient    (transient),
        .ack_write    (ack_write),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_line_idx (out_line_idx),
        .out_ready    (out_ready),
        .count        (count),
        .almost_full  (almost_full),
        .lines_in     (lines_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ordinary queue of lines plus the two line counters.
    logic [W-1:0] m_q [$];
    int unsigned  m_idx      = 0;
    int unsigned  m_lines    = 0;
    bit           m_ack_pend = 1'b0;
    bit           m_do_push;
    bit           m_do_pop;

    always @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            m_q.delete();
            m_idx      = 0;
            m_lines    = 0;
            m_ack_pend = 1'b0;
        end else begin
            m_do_push = !m_ack_pend && req_write && (m_q.size() < DEPTH);
            m_do_pop  = (m_q.size() > 0) && out_ready;
            if (m_do_pop) begin
                void'(m_q.pop_front());
                m_idx++;
            end
            if (m_do_push) begin
                m_q.push_back(transient);
                m_lines++;
            end
            m_ack_pend = m_do_push;
        end
    end

    always @(negedge clk) begin
        chk("m_ack_write",   W'(ack_write),    W'(m_ack_pend && !clear));
        chk("m_out_valid",   W'(out_valid),    W'(m_q.size() != 0));
        chk("m_count",       W'(count),        W'(m_q.size()));
        chk("m_almost_full", W'(almost_full),  W'(m_q.size() >= AF));
        chk("m_line_idx",    W'(out_line_idx), W'(m_idx));
        chk("m_lines_in",    W'(lines_in),     W'(m_lines));
        if (m_q.size() > 0) chk("m_out_data", out_data, m_q[0]);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one line and holds req_write until ack_write; lat = negedges waited.
    task automatic push_line(input logic [W-1:0] d, output int lat);
        lat       = 0;
        req_write = 1'b1;
        transient = d;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ack_write) begin
                lat = i;
                break;
            end
        end
        step();
        req_write = 1'b0;
        chk("ack_seen", W'(lat != 0), W'(1));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    int lat;
    bit found;

    initial begin
        #1 reset = 1'b1;
        repeat (3) step();
        chk("rst_ack",   W'(ack_write),    W'(0));
        chk("rst_valid", W'(out_valid),    W'(0));
        chk("rst_count", W'(count),        W'(0));
        chk("rst_af",    W'(almost_full),  W'(0));
        chk("rst_lines", W'(lines_in),     W'(0));
        chk("rst_idx",   W'(out_line_idx), W'(0));
        reset = 1'b0;
        step();

        // Single line
        push_line({64{8'hA5}}, lat);
        chk("single_lat",   W'(lat),          W'(2));
        chk("single_valid", W'(out_valid),    W'(1));
        chk("single_data",  out_data,         {64{8'hA5}});
        chk("single_idx",   W'(out_line_idx), W'(0));
        chk("single_count", W'(count),        W'(1));
        chk("single_lines", W'(lines_in),     W'(1));
        do_clear();
        chk("clr_count", W'(count), W'(0));

        // Fill to full, stall, then one pop lets line 16 in
        for (int i = 0; i < DEPTH; i++) begin
            push_line(W'(i), lat);
            chk("fill_count", W'(count),       W'(i + 1));
            chk("fill_af",    W'(almost_full), W'((i + 1) >= AF));
        end
        req_write = 1'b1;
        transient = W'(16);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_no_ack", W'(ack_write), W'(0));
            chk("stall_count",  W'(count),     W'(16));
        end
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (ack_write) begin
                found = 1'b1;
                break;
            end
        end
        chk("ack_after_pop", W'(found), W'(1));
        step();
        req_write = 1'b0;
        chk("after_pop_data",  out_data,         W'(1));
        chk("after_pop_idx",   W'(out_line_idx), W'(1));
        chk("after_pop_count", W'(count),        W'(16));
        chk("after_pop_lines", W'(lines_in),     W'(17));
        do_clear();

        // Drain order and index with continuous out_ready
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_line(W'(i), lat);
            chk("drain_cnt_le2", W'(count <= 5'd2), W'(1));
        end
        repeat (3) step();
        chk("drain_idx",   W'(out_line_idx), W'(20));
        chk("drain_lines", W'(lines_in),     W'(20));
        chk("drain_empty", W'(out_valid),    W'(0));
        out_ready = 1'b0;
        do_clear();

        // Simultaneous push and pop at count=5
        for (int i = 0; i < 5; i++) push_line(W'(100 + i), lat);
        req_write = 1'b1;
        transient = W'(200);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        req_write = 1'b0;
        @(negedge clk);
        chk("pp_ack",   W'(ack_write),    W'(1));
        chk("pp_count", W'(count),        W'(5));
        chk("pp_head",  out_data,         W'(101));
        chk("pp_idx",   W'(out_line_idx), W'(1));
        step();
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        chk("pp_tail",       out_data,         W'(200));
        chk("pp_tail_count", W'(count),        W'(1));
        chk("pp_tail_idx",   W'(out_line_idx), W'(5));
        do_clear();

        // clear in the ACK cycle
        for (int i = 0; i < 2; i++) push_line(W'(300 + i), lat);
        req_write = 1'b1;
        transient = W'(302);
        step();
        req_write = 1'b0;
        chk("ca_count_pre", W'(count), W'(3));
        clear = 1'b1;
        #1;
        chk("ca_ack", W'(ack_write), W'(0));
        step();
        clear = 1'b0;
        chk("ca_count", W'(count),        W'(0));
        chk("ca_valid", W'(out_valid),    W'(0));
        chk("ca_lines", W'(lines_in),     W'(0));
        chk("ca_idx",   W'(out_line_idx), W'(0));
        push_line(W'(400), lat);
        chk("ca_next_idx",   W'(out_line_idx), W'(0));
        chk("ca_next_lines", W'(lines_in),     W'(1));
        chk("ca_next_data",  out_data,         W'(400));
        do_clear();

        // Asynchronous reset mid-stream, during an ACK cycle
        for (int i = 0; i < 6; i++) push_line(W'(500 + i), lat);
        req_write = 1'b1;
        transient = W'(506);
        step();
        req_write = 1'b0;
        chk("ar_count_pre", W'(count),     W'(7));
        chk("ar_ack_pre",   W'(ack_write), W'(1));
        #1 reset = 1'b1;
        #1;
        chk("ar_ack",   W'(ack_write), W'(0));
        chk("ar_valid", W'(out_valid), W'(0));
        chk("ar_count", W'(count),     W'(0));
        step();
        reset = 1'b0;
        step();
        push_line(W'(600), lat);
        chk("ar_resume_count", W'(count),        W'(1));
        chk("ar_resume_lines", W'(lines_in),     W'(1));
        chk("ar_resume_data",  out_data,         W'(600));
        chk("ar_resume_idx",   W'(out_line_idx), W'(0));

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/grn_write_queue.md
Name: grn_write_queue

Overview:
- Decoupling queue between the top_grn result producer and grn_requestor's CCI-P c1 write path.
- Accepts 512-bit transient lines over the req_write/ack_write handshake and buffers them in a FIFO.
- Presents each line first-word-fall-through, with a monotonically increasing line index that the requestor uses as the write-address offset from the buffer base.
- Exposes occupancy and almost-full so the requestor can stall top_grn while c1TxAlmFull is asserted.

Parameters:
- LINE_WIDTH, 512, data bits per cache line.
- DEPTH, 16, entries; must be a power of two, at least 4.
- AFULL_THRESH, 12, almost_full asserts when count >= this value; range 1..DEPTH.

Ports:
- clk  in  1  AFU clock (pClkDiv2 domain).
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; pulse from requestor at job start.
- req_write  in  1  producer request, level; held until ack_write is seen.
- transient  in  LINE_WIDTH  producer line; stable while req_write=1.
- ack_write  out  1  one-cycle pulse; line accepted.
- out_valid  out  1  head entry valid.
- out_data  out  LINE_WIDTH  head line.
- out_line_idx  out  32  index of head line since last clear.
- out_ready  in  1  consumer pops head when out_valid&&out_ready.
- count  out  $clog2(DEPTH)+1  current occupancy.
- almost_full  out  1  count >= AFULL_THRESH.
- lines_in  out  32  total lines accepted since clear.

Behaviour:
- Reset (async, active-high) values:
  - ack_write=0, out_valid=0, out_line_idx=0, count=0, almost_full=0, lines_in=0.
  - Pointers=0; FSM=IDLE.
  - out_data undefined; the bench must not check it while out_valid=0.
- Accept FSM, 2 states:
  - IDLE: if req_write && count<DEPTH, write transient at wr_ptr, wr_ptr++, then go to ACK. Otherwise stay in IDLE.
  - ACK: ack_write=1 for exactly this cycle; req_write is ignored; return to IDLE.
  - Net effect: ack_write rises the cycle after the push edge. Maximum accept rate is 1 line per 2 cycles. This guarantees no double-accept, because the producer drops req_write in the cycle it sees ack_write.
- Full rule: no push when count==DEPTH, even if a pop happens in the same cycle. req_write waits in IDLE.
- Output side is FWFT:
  - out_valid = (count!=0).
  - out_data = mem[rd_ptr], valid in the same cycle out_valid is high.
  - Pop when out_valid&&out_ready: rd_ptr++, out_line_idx++.
  - out_ready while out_valid=0 has no effect.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Wrap rules:
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - out_line_idx and lines_in wrap modulo 2^32 with no flag.
- count updates are registered: the value after an edge reflects the push/pop of that edge.
- almost_full is a registered compare of the next count, so it is consistent with count in the same cycle.
- clear:
  - Synchronous, with priority over push and pop.
  - Zeroes pointers, count, out_line_idx and lines_in; FSM goes to IDLE.
  - An ACK in flight is dropped: ack_write=0 that cycle and the line is discarded.
  - Mem contents are not cleared.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronous); queued lines are lost.
- Memory: simple dual-port, synchronous write, asynchronous/LUT read (FWFT). Read-during-write to the same address cannot occur, because push is blocked when full and the head is only read when count>0.

Decomposition:
- Add to grn_pkg:
  - GRN_LINE_WIDTH=512.
  - GRN_WQ_DEPTH=16.
  - typedef t_grn_line (logic [511:0]).
  - typedef t_grn_line_idx (logic [31:0]).
  - enum t_grn_wq_state {GRN_WQ_IDLE, GRN_WQ_ACK}.
- One sub-module, grn_wq_ram: DEPTH x LINE_WIDTH storage with one write port and one asynchronous read port. The FSM, pointers and counters stay in grn_write_queue.

Test Plan:
- Single line:
  - Stimulus: after reset, req_write=1 with transient=512'hA5..A5, out_ready=0.
  - Required: ack_write pulses one cycle after the push edge; out_valid=1, out_data=A5..A5, out_line_idx=0, count=1, lines_in=1.
- Fill to full:
  - Stimulus: out_ready=0, 17 lines offered with data=i.
  - Required: 16 acks; almost_full rises when count=12; req_write 17 stalls with no ack while count=16.
  - Then: assert out_ready for 1 cycle → line 0 pops; line 16 is acked within 2 cycles.
- Drain order and index:
  - Stimulus: push data 0..19 with out_ready=1 continuously.
  - Required: out_data sequence 0..19 with out_line_idx 0..19 in order; pointers wrap past 15 with no corruption; count never exceeds 2.
- Simultaneous push/pop:
  - Stimulus: count=5, a push edge coincides with a pop.
  - Required: count stays 5; head advances; new line lands at tail.
- clear during ACK:
  - Stimulus: clear asserted in the ACK cycle with count=3.
  - Required: ack_write=0; count=0, out_valid=0, lines_in=0, out_line_idx=0 next cycle; the next push yields out_line_idx=0.
- Async reset mid-stream:
  - Stimulus: reset asserted between clock edges with count=7.
  - Required: out_valid, ack_write and count go to 0 without waiting for clk; after release, normal accept resumes.
